multicycle_ctrl: RTL and testbench

- Multi-cycle control unit that sequences the existing core datapath (fetch, decode, execute, data memory, write-back mux).
- Replaces the externally driven control inputs of the core.
- Decodes RV32I R-type, I-ALU, LOAD, STORE and BEQ/BNE.
- Drives mux selects, write/read enables and ALU control one phase per cycle; waits on a data-memory ready handshake; traps on illegal opcodes and memory timeouts.

---
 rtl/multicycle_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle control unit for the RV32I core datapath. It steps through
//   fetch, decode, execute, data memory and write-back, one phase per cycle.
//   It waits on the data-memory ready handshake and traps on an illegal opcode
//   or on a memory access that never completes.
//
//   State | Meaning
//   ------+-----------------------------------------------------------------
//   FETCH | load IR from instruction memory (irWrite)
//   DECODE| latch opcode/funct3/funct7b5, check legality
//   EXEC  | ALU operation; branches resolve and retire here
//   MEM   | data memory access, held until memReady or timeout
//   WB    | register write-back, PC+4, retire
//   TRAP  | illegal instruction or memory timeout; held until reset
//
// Ports
//   clk, rst             clock (rising edge), async active-low reset
//   opcode/funct3/...    instruction fields from the datapath IR
//   zero                 ALU zero flag (branch resolution)
//   memReady             data memory access complete
//   irWrite..memRead     datapath enables and mux selects
//   aluCtrl              ALU operation code
//   illegal              trap flag
//   retire               one-cycle pulse per completed instruction
//   state                current FSM state (debug)
// ----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       memReady,
    output logic       irWrite,
    output logic       pcWrite,
    output logic       mux1Sel,
    output logic       mux2Sel,
    output logic       mux3Sel,
    output logic       regWrite,
    output logic       memWrite,
    output logic       memRead,
    output logic [3:0] aluCtrl,
    output logic       illegal,
    output logic       retire,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        TRAP    = 3'd5
    } state_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [2:0]       f3_q, f3_d;
    logic             f7_q, f7_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       legal_in;
    logic       is_r, is_i, is_ld, is_st, is_br;
    logic [3:0] alu_sel;

    logic       ir_c, pc_c, m1_c, m2_c, m3_c, rw_c, mw_c, mr_c, ill_c, ret_c;
    logic [3:0] alu_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            op_q    <= '0;
            f3_q    <= '0;
            f7_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            f3_q    <= f3_d;
            f7_q    <= f7_d;
            cnt_q   <= cnt_d;
        end
    end

    // Legality is judged on the live IR fields during DECODE, the same cycle
    // they are captured.
    always_comb begin
        legal_in = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LD) ||
                   (opcode == OP_ST) ||
                   ((opcode == OP_BR) && (funct3[2:1] == 2'b00));
    end

    always_comb begin
        is_r  = (op_q == OP_R);
        is_i  = (op_q == OP_I);
        is_ld = (op_q == OP_LD);
        is_st = (op_q == OP_ST);
        is_br = (op_q == OP_BR);
    end

    // ALU operation from the latched fields. Loads and stores compute an
    // address (ADD); branches compare (SUB). For I-type, funct7b5 only
    // distinguishes SRAI, since bit 30 of ADDI is part of the immediate.
    always_comb begin
        alu_sel = ALU_ADD;
        if (is_br) begin
            alu_sel = ALU_SUB;
        end else if (is_r || is_i) begin
            case (f3_q)
                3'b000:  alu_sel = (is_r && f7_q) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_sel = ALU_SLL;
                3'b010:  alu_sel = ALU_SLT;
                3'b011:  alu_sel = ALU_SLTU;
                3'b100:  alu_sel = ALU_XOR;
                3'b101:  alu_sel = f7_q ? ALU_SRA : ALU_SRL;
                3'b110:  alu_sel = ALU_OR;
                3'b111:  alu_sel = ALU_AND;
                default: alu_sel = ALU_ADD;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        f3_d    = f3_q;
        f7_d    = f7_q;
        cnt_d   = cnt_q;
        ir_c    = 1'b0;
        pc_c    = 1'b0;
        m1_c    = 1'b0;
        m2_c    = 1'b0;
        m3_c    = 1'b0;
        rw_c    = 1'b0;
        mw_c    = 1'b0;
        mr_c    = 1'b0;
        ill_c   = 1'b0;
        ret_c   = 1'b0;
        alu_c   = ALU_ADD;

        case (state_q)
            FETCH: begin
                ir_c    = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                op_d    = opcode;
                f3_d    = funct3;
                f7_d    = funct7b5;
                state_d = legal_in ? EXECUTE : TRAP;
            end
            EXECUTE: begin
                alu_c = alu_sel;
                m2_c  = is_i || is_ld || is_st;
                if (is_br) begin
                    // funct3[0]: 0 = BEQ (taken on zero), 1 = BNE
                    m1_c    = f3_q[0] ? !zero : zero;
                    pc_c    = 1'b1;
                    ret_c   = 1'b1;
                    state_d = FETCH;
                end else if (is_ld || is_st) begin
                    cnt_d   = '0;
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                alu_c = ALU_ADD;
                m2_c  = 1'b1;
                mr_c  = is_ld;
                mw_c  = is_st;
                // Ready on the last allowed cycle completes the access.
                if (memReady) begin
                    if (is_ld) begin
                        state_d = WB;
                    end else begin
                        pc_c    = 1'b1;
                        ret_c   = 1'b1;
                        state_d = FETCH;
                    end
                end else if (cnt_q == MEM_LAST) begin
                    state_d = TRAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WB: begin
                // ALU op and operand select stay as in EXECUTE so the
                // result being written back is still valid.
                alu_c   = alu_sel;
                m2_c    = is_i || is_ld;
                m3_c    = is_ld;
                rw_c    = 1'b1;
                pc_c    = 1'b1;
                ret_c   = 1'b1;
                state_d = FETCH;
            end
            TRAP: begin
                ill_c = 1'b1;
            end
            default: begin
                state_d = TRAP;
            end
        endcase
    end

    // Outputs are forced low while reset is held so that an access in flight
    // is released immediately, without waiting for a clock edge.
    always_comb begin
        irWrite  = rst & ir_c;
        pcWrite  = rst & pc_c;
        mux1Sel  = rst & m1_c;
        mux2Sel  = rst & m2_c;
        mux3Sel  = rst & m3_c;
        regWrite = rst & rw_c;
        memWrite = rst & mw_c;
        memRead  = rst & mr_c;
        illegal  = rst & ill_c;
        retire   = rst & ret_c;
        aluCtrl  = rst ? alu_c : ALU_ADD;
        state    = state_q;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_XX = 7'b1111111;

    localparam logic [3:0] A_ADD  = 4'b0000;
    localparam logic [3:0] A_SUB  = 4'b0001;
    localparam logic [3:0] A_AND  = 4'b0010;
    localparam logic [3:0] A_OR   = 4'b0011;
    localparam logic [3:0] A_XOR  = 4'b0100;
    localparam logic [3:0] A_SLL  = 4'b0101;
    localparam logic [3:0] A_SRL  = 4'b0110;
    localparam logic [3:0] A_SRA  = 4'b0111;
    localparam logic [3:0] A_SLT  = 4'b1000;
    localparam logic [3:0] A_SLTU = 4'b1001;

    localparam logic [2:0] S_FE = 3'd0;
    localparam logic [2:0] S_DE = 3'd1;
    localparam logic [2:0] S_EX = 3'd2;
    localparam logic [2:0] S_ME = 3'd3;
    localparam logic [2:0] S_WB = 3'd4;
    localparam logic [2:0] S_TR = 3'd5;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic        rdy;
        logic [2:0]  st;
        logic [13:0] o;
    } vec_t;

    typedef struct packed {
        logic [2:0]  st;
        logic [13:0] o;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       memReady;
    logic       irWrite, pcWrite, mux1Sel, mux2Sel, mux3Sel;
    logic       regWrite, memWrite, memRead, illegal, retire;
    logic [3:0] aluCtrl;
    logic [2:0] state;

    int   total;
    int   bad;
    int   step;
    vec_t tbl[$];
    exp_t sb[$];

    multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .zero     (zero),
        .memReady (memReady),
        .irWrite  (irWrite),
        .pcWrite  (pcWrite),
        .mux1Sel  (mux1Sel),
        .mux2Sel  (mux2Sel),
        .mux3Sel  (mux3Sel),
        .regWrite (regWrite),
        .memWrite (memWrite),
        .memRead  (memRead),
        .aluCtrl  (aluCtrl),
        .illegal  (illegal),
        .retire   (retire),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {irWrite,pcWrite,mux1Sel,mux2Sel,mux3Sel,regWrite,memWrite,memRead,aluCtrl,illegal,retire}
    function automatic logic [13:0] mk_o(input logic ir, input logic pc, input logic m1,
                                         input logic m2, input logic m3, input logic rw,
                                         input logic mw, input logic mr, input logic [3:0] alu,
                                         input logic ill, input logic ret);
        return {ir, pc, m1, m2, m3, rw, mw, mr, alu, ill, ret};
    endfunction

    function automatic logic [13:0] act_o();
        return {irWrite, pcWrite, mux1Sel, mux2Sel, mux3Sel, regWrite,
                memWrite, memRead, aluCtrl, illegal, retire};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d: got %0h want %0h", name, step, act, exp);
        end
    endtask

    task automatic push_v(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input logic z, input logic rdy, input logic [2:0] st,
                          input logic [13:0] o);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.rdy = rdy; v.st = st; v.o = o;
        tbl.push_back(v);
    endtask

    // Later cycles drive junk on the IR fields: only the latched copy counts.
    task automatic push_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic [3:0] alu);
        logic m2;
        m2 = (op == OP_I);
        push_v(op, f3, f7, L, L, S_FE, mk_o(H,L,L,L,L,L,L,L,A_ADD,L,L));
        push_v(op, f3, f7, L, L, S_DE, mk_o(L,L,L,L,L,L,L,L,A_ADD,L,L));
        push_v(OP_XX, ~f3, ~f7, H, H, S_EX, mk_o(L,L,L,m2,L,L,L,L,alu,L,L));
        push_v(OP_XX, ~f3, ~f7, H, H, S_WB, mk_o(L,H,L,m2,L,H,L,L,alu,L,H));
    endtask

    task automatic push_br(input logic [2:0] f3, input logic z, input logic m1);
        push_v(OP_BR, f3, L, L, L, S_FE, mk_o(H,L,L,L,L,L,L,L,A_ADD,L,L));
        push_v(OP_BR, f3, L, L, L, S_DE, mk_o(L,L,L,L,L,L,L,L,A_ADD,L,L));
        push_v(OP_R, ~f3, H, z, L, S_EX, mk_o(L,H,m1,L,L,L,L,L,A_SUB,L,H));
    endtask

    task automatic push_mem(input logic ld, input int waits);
        logic [6:0] op;
        op = ld ? OP_LD : OP_ST;
        push_v(op, 3'b010, L, L, L, S_FE, mk_o(H,L,L,L,L,L,L,L,A_ADD,L,L));
        push_v(op, 3'b010, L, L, L, S_DE, mk_o(L,L,L,L,L,L,L,L,A_ADD,L,L));
        push_v(OP_XX, 3'b111, H, L, L, S_EX, mk_o(L,L,L,H,L,L,L,L,A_ADD,L,L));
        for (int i = 0; i < waits; i++)
            push_v(OP_XX, 3'b111, H, L, L, S_ME, mk_o(L,L,L,H,L,L,~ld,ld,A_ADD,L,L));
        if (ld) begin
            push_v(OP_XX, 3'b111, H, L, H, S_ME, mk_o(L,L,L,H,L,L,L,H,A_ADD,L,L));
            push_v(OP_XX, 3'b111, H, L, L, S_WB, mk_o(L,H,L,H,H,H,L,L,A_ADD,L,H));
        end else begin
            push_v(OP_XX, 3'b111, H, L, H, S_ME, mk_o(L,H,L,H,L,L,H,L,A_ADD,L,H));
        end
    endtask

    task automatic run_cycle(input vec_t v);
        exp_t e;
        @(negedge clk);
        opcode   = v.op;
        funct3   = v.f3;
        funct7b5 = v.f7;
        zero     = v.z;
        memReady = v.rdy;
        sb.push_back({v.st, v.o});
        #1;
        e = sb.pop_front();
        check("state", 32'(state), 32'(e.st));
        check("outs", 32'(act_o()), 32'(e.o));
        step++;
    endtask

    task automatic cyc(input logic [6:0] op, input logic [2:0] f3, input logic rdy,
                       input logic [2:0] st, input logic [13:0] o);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = L; v.z = L; v.rdy = rdy; v.st = st; v.o = o;
        run_cycle(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'(S_FE));
        check("rst_outs", 32'(act_o()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        total = 0; bad = 0; step = 0;
        rst = 1'b0; opcode = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; memReady = 1'b0;

        push_alu(OP_R, 3'b000, L, A_ADD);
        push_alu(OP_R, 3'b000, H, A_SUB);
        push_alu(OP_I, 3'b000, H, A_ADD);
        push_alu(OP_I, 3'b101, H, A_SRA);
        push_alu(OP_I, 3'b101, L, A_SRL);
        push_alu(OP_R, 3'b101, L, A_SRL);
        push_alu(OP_R, 3'b101, H, A_SRA);
        push_alu(OP_R, 3'b111, L, A_AND);
        push_alu(OP_I, 3'b110, L, A_OR);
        push_alu(OP_R, 3'b100, L, A_XOR);
        push_alu(OP_I, 3'b001, L, A_SLL);
        push_alu(OP_R, 3'b010, L, A_SLT);
        push_alu(OP_I, 3'b011, L, A_SLTU);
        push_br(3'b000, H, H);
        push_br(3'b001, H, L);
        push_br(3'b000, L, L);
        push_br(3'b001, L, H);
        push_mem(H, 3);
        push_mem(H, 0);
        push_mem(L, 0);
        push_mem(L, 15);
        push_alu(OP_R, 3'b110, L, A_OR);

        #3;
        check("init_state", 32'(state), 32'(S_FE));
        check("init_outs", 32'(act_o()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        foreach (tbl[i]) run_cycle(tbl[i]);

        // store that never completes: 16 MEM cycles, then trap
        cyc(OP_ST, 3'b010, L, S_FE, mk_o(H,L,L,L,L,L,L,L,A_ADD,L,L));
        cyc(OP_ST, 3'b010, L, S_DE, mk_o(L,L,L,L,L,L,L,L,A_ADD,L,L));
        cyc(OP_XX, 3'b000, L, S_EX, mk_o(L,L,L,H,L,L,L,L,A_ADD,L,L));
        for (int i = 0; i < 16; i++)
            cyc(OP_XX, 3'b000, L, S_ME, mk_o(L,L,L,H,L,L,H,L,A_ADD,L,L));
        for (int i = 0; i < 4; i++)
            cyc(OP_R, 3'b000, H, S_TR, mk_o(L,L,L,L,L,L,L,L,A_ADD,H,L));
        do_reset();

        // illegal opcode
        cyc(OP_XX, 3'b000, L, S_FE, mk_o(H,L,L,L,L,L,L,L,A_ADD,L,L));
        cyc(OP_XX, 3'b000, L, S_DE, mk_o(L,L,L,L,L,L,L,L,A_ADD,L,L));
        for (int i = 0; i < 3; i++)
            cyc(OP_R, 3'b000, H, S_TR, mk_o(L,L,L,L,L,L,L,L,A_ADD,H,L));
        do_reset();

        // branch with unsupported funct3
        cyc(OP_BR, 3'b100, L, S_FE, mk_o(H,L,L,L,L,L,L,L,A_ADD,L,L));
        cyc(OP_BR, 3'b100, L, S_DE, mk_o(L,L,L,L,L,L,L,L,A_ADD,L,L));
        for (int i = 0; i < 3; i++)
            cyc(OP_BR, 3'b000, H, S_TR, mk_o(L,L,L,L,L,L,L,L,A_ADD,H,L));
        do_reset();

        // reset asserted mid-MEM, away from any clock edge
        cyc(OP_ST, 3'b010, L, S_FE, mk_o(H,L,L,L,L,L,L,L,A_ADD,L,L));
        cyc(OP_ST, 3'b010, L, S_DE, mk_o(L,L,L,L,L,L,L,L,A_ADD,L,L));
        cyc(OP_XX, 3'b000, L, S_EX, mk_o(L,L,L,H,L,L,L,L,A_ADD,L,L));
        cyc(OP_XX, 3'b000, L, S_ME, mk_o(L,L,L,H,L,L,H,L,A_ADD,L,L));
        #1;
        rst = 1'b0;
        #1;
        check("async_memWrite", 32'(memWrite), 32'd0);
        check("async_state", 32'(state), 32'(S_FE));
        check("async_outs", 32'(act_o()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(OP_R, 3'b000, L, S_FE, mk_o(H,L,L,L,L,L,L,L,A_ADD,L,L));
        cyc(OP_R, 3'b000, L, S_DE, mk_o(L,L,L,L,L,L,L,L,A_ADD,L,L));
        cyc(OP_XX, 3'b000, L, S_EX, mk_o(L,L,L,L,L,L,L,L,A_ADD,L,L));
        cyc(OP_XX, 3'b000, L, S_WB, mk_o(L,H,L,L,L,H,L,L,A_ADD,L,H));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
